// File: rtl/eth_tx_arb_pkg.sv
// Shared state encoding, default timing parameters and helpers for the
// two-source Ethernet TX arbiter.
package eth_tx_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_XFER = 3'b010,
    ST_GAP  = 3'b100
  } state_t;

  localparam int          IFG_DEFAULT     = 12;
  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_tx_watchdog.sv
// Silent-cycle watchdog: expires when TIMEOUT consecutive enabled cycles
// pass without activity. TIMEOUT of zero never expires.
module eth_tx_watchdog
  import eth_tx_arb_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic activity,
  input  logic enable,
  output logic expire
);

  localparam logic [15:0] LAST = TIMEOUT - 16'd1;

  logic [15:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clear || activity) begin
      cnt_reg <= 16'd0;
    end else if (enable) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  // Fires on the cycle that would complete the TIMEOUT-th silent cycle.
  assign expire = enable && (TIMEOUT != 16'd0) && !clear && !activity &&
                  (cnt_reg == LAST);

endmodule

// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter muxing two frame sources onto one Ethernet TX write
// port, with inter-frame gap, length check and silent-frame watchdog.
module eth_tx_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int          IFG_CYCLES = IFG_DEFAULT,
  parameter logic [15:0] TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [7:0]  s0_data,
  input  logic        s0_pulse,
  input  logic        s0_over,
  input  logic [15:0] s0_length,
  input  logic [7:0]  s1_data,
  input  logic        s1_pulse,
  input  logic        s1_over,
  input  logic [15:0] s1_length,
  output logic [7:0]  m_data,
  output logic        m_pulse,
  output logic        m_over,
  output logic [15:0] m_length,
  output logic        busy,
  output logic        timeout_err,
  output logic        len_err
);

  localparam logic [15:0] GAP_LAST = (IFG_CYCLES < 1) ? 16'd0 : 16'(IFG_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [1:0]  gnt_reg, gnt_next;
  logic        ptr_reg, ptr_next;
  logic [15:0] byte_cnt_reg, byte_cnt_next;
  logic [15:0] gap_cnt_reg, gap_cnt_next;
  logic [7:0]  m_data_reg, m_data_next;
  logic        m_pulse_reg, m_pulse_next;
  logic        m_over_reg, m_over_next;
  logic [15:0] m_length_reg, m_length_next;
  logic        timeout_reg, timeout_next;
  logic        len_err_reg, len_err_next;
  logic        end_frame;

  logic        sel, g_req, g_pulse, g_over, expire;
  logic [7:0]  g_data;
  logic [15:0] g_length, cnt_inc;

  // gnt_reg is zero outside XFER, so masking with it also qualifies by state.
  assign sel      = gnt_reg[1];
  assign g_req    = |(gnt_reg & req);
  assign g_pulse  = |(gnt_reg & {s1_pulse, s0_pulse});
  assign g_over   = |(gnt_reg & {s1_over, s0_over});
  assign g_data   = sel ? s1_data : s0_data;
  assign g_length = sel ? s1_length : s0_length;
  assign cnt_inc  = g_pulse ? sat_inc(byte_cnt_reg) : byte_cnt_reg;

  eth_tx_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_reg != ST_XFER),
    .activity (g_pulse | g_over),
    .enable   (state_reg == ST_XFER),
    .expire   (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      gnt_reg      <= 2'b00;
      ptr_reg      <= 1'b0;
      byte_cnt_reg <= 16'd0;
      gap_cnt_reg  <= 16'd0;
      m_data_reg   <= 8'd0;
      m_pulse_reg  <= 1'b0;
      m_over_reg   <= 1'b0;
      m_length_reg <= 16'd0;
      timeout_reg  <= 1'b0;
      len_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      ptr_reg      <= ptr_next;
      byte_cnt_reg <= byte_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      m_data_reg   <= m_data_next;
      m_pulse_reg  <= m_pulse_next;
      m_over_reg   <= m_over_next;
      m_length_reg <= m_length_next;
      timeout_reg  <= timeout_next;
      len_err_reg  <= len_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    ptr_next      = ptr_reg;
    byte_cnt_next = byte_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    m_data_next   = m_data_reg;
    m_length_next = m_length_reg;
    m_pulse_next  = 1'b0;
    m_over_next   = 1'b0;
    timeout_next  = 1'b0;
    len_err_next  = 1'b0;
    end_frame     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req != 2'b00) begin
          gnt_next      = (req == 2'b11) ? (ptr_reg ? 2'b10 : 2'b01) : req;
          byte_cnt_next = 16'd0;
          state_next    = ST_XFER;
        end
      end
      ST_XFER: begin
        byte_cnt_next = cnt_inc;
        if (g_pulse) begin
          m_pulse_next = 1'b1;
          m_data_next  = g_data;
        end
        if (g_over) begin
          m_over_next   = 1'b1;
          m_length_next = g_length;
          len_err_next  = (cnt_inc != g_length);
          end_frame     = 1'b1;
        end else if (!g_req || expire) begin
          timeout_next = 1'b1;
          end_frame    = 1'b1;
        end
        if (end_frame) begin
          gnt_next     = 2'b00;
          ptr_next     = ~sel;
          gap_cnt_next = GAP_LAST;
          state_next   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg == 16'd0) begin
          state_next = ST_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - 16'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        gnt_next   = 2'b00;
      end
    endcase
  end

  assign gnt         = gnt_reg;
  assign m_data      = m_data_reg;
  assign m_pulse     = m_pulse_reg;
  assign m_over      = m_over_reg;
  assign m_length    = m_length_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign timeout_err = timeout_reg;
  assign len_err     = len_err_reg;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Randomized bench: two synthetic frame sources drive the arbiter and every
// cycle is compared against a frame-level behavioural model.
module tb_eth_tx_arbiter;

  localparam int          IFG = 12;
  localparam logic [15:0] TMO = 16'd20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [7:0]  s0_data = 8'd0, s1_data = 8'd0;
  logic        s0_pulse = 1'b0, s1_pulse = 1'b0;
  logic        s0_over = 1'b0, s1_over = 1'b0;
  logic [15:0] s0_length = 16'd0, s1_length = 16'd0;
  logic [1:0]  gnt;
  logic [7:0]  m_data;
  logic        m_pulse, m_over, busy, timeout_err, len_err;
  logic [15:0] m_length;

  always #5 clk = ~clk;

  eth_tx_arbiter #(.IFG_CYCLES(IFG), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .s0_data(s0_data), .s0_pulse(s0_pulse), .s0_over(s0_over), .s0_length(s0_length),
    .s1_data(s1_data), .s1_pulse(s1_pulse), .s1_over(s1_over), .s1_length(s1_length),
    .m_data(m_data), .m_pulse(m_pulse), .m_over(m_over), .m_length(m_length),
    .busy(busy), .timeout_err(timeout_err), .len_err(len_err)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 frame owned by md_owner, 2 inter-frame gap.
  int md_mode = 0, md_owner = 0, md_ptr = 0, md_cnt = 0, md_silent = 0, md_gap = 0;
  logic [1:0]  e_gnt = 2'b00;
  logic [7:0]  e_data = 8'd0;
  logic [15:0] e_length = 16'd0;
  logic        e_pulse = 1'b0, e_over = 1'b0, e_tmo = 1'b0, e_len = 1'b0, e_busy = 1'b0;

  task automatic model_step();
    logic p, o, r, closed;
    logic [7:0]  d;
    logic [15:0] l;
    e_pulse = 1'b0; e_over = 1'b0; e_tmo = 1'b0; e_len = 1'b0;
    if (rst) begin
      md_mode = 0; md_ptr = 0; md_cnt = 0; md_silent = 0;
      e_gnt = 2'b00; e_data = 8'd0; e_length = 16'd0; e_busy = 1'b0;
      return;
    end
    case (md_mode)
      0: if (req != 2'b00) begin
        md_owner  = (req == 2'b11) ? md_ptr : (req[1] ? 1 : 0);
        e_gnt     = 2'(1 << md_owner);
        md_mode   = 1;
        md_cnt    = 0;
        md_silent = 0;
      end
      1: begin
        p = md_owner ? s1_pulse : s0_pulse;
        o = md_owner ? s1_over : s0_over;
        d = md_owner ? s1_data : s0_data;
        l = md_owner ? s1_length : s0_length;
        r = req[md_owner];
        closed = 1'b0;
        if (p) begin
          e_pulse = 1'b1; e_data = d; md_silent = 0;
          if (md_cnt < 65535) md_cnt++;
        end
        if (o) begin
          e_over = 1'b1; e_length = l; e_len = (md_cnt != int'(l)); closed = 1'b1;
        end else if (!r) begin
          e_tmo = 1'b1; closed = 1'b1;
        end else if (!p) begin
          md_silent++;
          if (TMO != 0 && md_silent == int'(TMO)) begin
            e_tmo = 1'b1; closed = 1'b1;
          end
        end
        if (closed) begin
          e_gnt = 2'b00; md_ptr = 1 - md_owner; md_mode = 2;
          md_gap = (IFG < 1) ? 1 : IFG;
        end
      end
      default: begin
        md_gap--;
        if (md_gap == 0) md_mode = 0;
      end
    endcase
    e_busy = (md_mode != 0);
  endtask

  task automatic compare_all();
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("m_pulse", 32'(m_pulse), 32'(e_pulse));
    check("m_data", 32'(m_data), 32'(e_data));
    check("m_over", 32'(m_over), 32'(e_over));
    check("m_length", 32'(m_length), 32'(e_length));
    check("busy", 32'(busy), 32'(e_busy));
    check("timeout_err", 32'(timeout_err), 32'(e_tmo));
    check("len_err", 32'(len_err), 32'(e_len));
    check("gnt_two_hot", 32'(gnt == 2'b11), 32'd0);
    if (m_pulse) check("leak_55", 32'(m_data == 8'h55), 32'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1 compare_all();
  endtask

  // Synthetic sources. kind: 0 normal, 1 wrong length, 2 go silent, 3 drop req.
  logic s_req[2], s_wasg[2];
  int   s_plan[2], s_sent[2], s_kind[2];

  task automatic new_plan(input int k);
    int r;
    r = $urandom_range(0, 99);
    s_plan[k] = $urandom_range(1, 6);
    s_sent[k] = 0;
    s_kind[k] = (r < 70) ? 0 : (r < 82) ? 1 : (r < 91) ? 2 : 3;
  endtask

  task automatic drive();
    logic       p[2], o[2];
    logic [7:0] d[2];
    logic [15:0] l[2];
    rst = ($urandom_range(0, 499) == 0);
    for (int k = 0; k < 2; k++) begin
      logic g;
      g = e_gnt[k];
      if (s_wasg[k] && !g) begin
        new_plan(k);
        if ($urandom_range(0, 2) == 0) s_req[k] = 1'b0;
      end
      s_wasg[k] = g;
      if (!s_req[k] && $urandom_range(0, 5) == 0) begin
        s_req[k] = 1'b1;
        new_plan(k);
      end
      p[k] = 1'b0; o[k] = 1'b0;
      l[k] = 16'($urandom);
      if (g) begin
        d[k] = 8'($urandom_range(0, 255));
        if (d[k] == 8'h55) d[k] = 8'hA5;
        case (s_kind[k])
          2: if (s_sent[k] == 0) begin p[k] = 1'b1; s_sent[k]++; end
          3: begin
            if (s_sent[k] == 0) begin p[k] = 1'b1; s_sent[k]++; end
            else s_req[k] = 1'b0;
          end
          default: begin
            if (s_sent[k] < s_plan[k]) begin
              if ($urandom_range(0, 1) == 1) begin p[k] = 1'b1; s_sent[k]++; end
              if (p[k] && s_sent[k] == s_plan[k] && $urandom_range(0, 2) == 0) o[k] = 1'b1;
            end else begin
              o[k] = 1'b1;
            end
            if (o[k]) l[k] = 16'(s_plan[k] + ((s_kind[k] == 1) ? $urandom_range(1, 3) : 0));
          end
        endcase
      end else begin
        d[k] = 8'h55;
        p[k] = ($urandom_range(0, 3) == 0);
        o[k] = ($urandom_range(0, 15) == 0);
      end
    end
    req = {s_req[1], s_req[0]};
    s0_data = d[0]; s0_pulse = p[0]; s0_over = o[0]; s0_length = l[0];
    s1_data = d[1]; s1_pulse = p[1]; s1_over = o[1]; s1_length = l[1];
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      s_req[k] = 1'b0; s_wasg[k] = 1'b0;
      new_plan(k);
    end
    rst = 1'b1;
    cycle();
    cycle();
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      drive();
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 Parameter IFG_CYCLES, default 12, SHALL set idle cycles enforced between consecutive granted frames.
REQ-002 Parameter TIMEOUT, default 16'd50000, SHALL set the maximum silent cycles allowed inside a granted frame; 0 SHALL disable the watchdog.
REQ-003 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  2  per-source frame request; bit k SHALL belong to source k.
REQ-006 gnt  output  2  one-hot grant, or 2'b00 when no grant is active.
REQ-007 s0_data / s1_data  input  8  source byte.
REQ-008 s0_pulse / s1_pulse  input  1  source byte strobe.
REQ-009 s0_over / s1_over  input  1  source end-of-frame strobe.
REQ-010 s0_length / s1_length  input  16  source frame byte count, valid with its over.
REQ-011 m_data  output  8  byte to Ethernet TX write port.
REQ-012 m_pulse  output  1  byte strobe to TX write port.
REQ-013 m_over  output  1  end-of-frame strobe to TX write port.
REQ-014 m_length  output  16  frame length, valid with m_over.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 timeout_err  output  1  one-cycle pulse on watchdog abort.
REQ-017 len_err  output  1  one-cycle pulse with m_over when forwarded byte count differs from granted sN_length.

Function
REQ-018 FSM states SHALL be IDLE, XFER and GAP, one-hot encoded.
REQ-019 IDLE: with any req bit high, the arbiter SHALL assert the selected gnt bit on the next cycle and enter XFER.
REQ-020 Selection SHALL be round-robin: priority pointer = 0 after reset; after a frame from source k ends (normally or aborted), priority SHALL pass to source 1-k.
REQ-021 Both req bits high in IDLE SHALL grant the priority source; one bit high SHALL grant that source regardless of pointer.
REQ-022 XFER: the granted source's data/pulse/over/length SHALL appear on m_* with exactly 1 cycle latency; the ungranted source's strobes SHALL be ignored.
REQ-023 m_pulse and m_over SHALL be single-cycle copies of the granted strobes; m_data and m_length SHALL hold their last value otherwise.
REQ-024 A 16-bit byte counter SHALL clear on grant and increment on each granted pulse, saturating at 16'hFFFF.
REQ-025 Granted pulse and over in the same cycle SHALL forward the byte, count it, and close the frame.
REQ-026 Granted over SHALL clear gnt next cycle, compare counter to sN_length (mismatch -> len_err with m_over), and enter GAP.
REQ-027 Watchdog counter SHALL clear on grant and on every granted pulse/over; reaching TIMEOUT SHALL clear gnt, pulse timeout_err, emit no m_over, and enter GAP.
REQ-028 Granted req deasserting before over SHALL abort identically to a timeout.
REQ-029 GAP SHALL last max(IFG_CYCLES,1) cycles, then enter IDLE; requests arriving during GAP SHALL be held, not lost, since req is level.
REQ-030 gnt SHALL never be two-hot; gnt SHALL change only on IDLE->XFER and XFER->GAP transitions.

Reset
REQ-031 rst high SHALL, at the next edge, force IDLE, gnt=0, m_data=0, m_pulse=0, m_over=0, m_length=0, busy=0, timeout_err=0, len_err=0, counters=0, pointer=0.
REQ-032 Reset mid-frame SHALL drop the frame silently with no m_over, len_err or timeout_err.

Structure
REQ-033 Package eth_tx_arb_pkg SHALL hold the state encodings and IFG_CYCLES/TIMEOUT defaults.
REQ-034 The watchdog SHALL be a sub-module eth_tx_watchdog (clear, activity, enable inputs; expire pulse output).

Verification
REQ-035 req=2'b01, source 0 sends 4 bytes 0xA1..0xA4 then over with length 4 -> m_* mirror with 1-cycle delay, m_length=4, len_err=0, gnt 01 then 00.
REQ-036 req=2'b11 held from reset, each frame 2 bytes -> grants alternate 01,10,01 with >=12 idle cycles between m_over and next m_pulse.
REQ-037 Source 0 granted, source 1 pulses 0x55 meanwhile -> 0x55 never on m_data.
REQ-038 TIMEOUT=20, granted source silent after 1 byte -> timeout_err at 20 silent cycles, no m_over, gnt cleared, priority passes to source 1.
REQ-039 3 bytes sent, over with length 5 -> m_length=5 and len_err pulse coincident with m_over.
REQ-040 rst asserted after 2 bytes of a frame -> all outputs 0 next cycle, no m_over; new request after release granted to source 0.
